spi_fwm_rxf_ctrl: RTL
=====================

Name: spi_fwm_rxf_ctrl

Overview:
- RX-direction companion to the SPI firmware-mode TX FIFO controller.
- Pops bytes from the SPI RX byte FIFO and packs them little-endian into SramDw-bit words.
- Writes each word with a byte mask into a circular region of the shared SPI SRAM bounded by base/limit word indices.
- Advances a byte-granular write pointer that software consumes against its own read pointer; a partial word is flushed after a programmable idle timeout.

Parameters:
- FifoDw, 8, RX FIFO byte width (must be 8).
- SramAw, 11, SRAM word address width.
- SramDw, 32, SRAM data width; NumBytes = SramDw/8, SDW = clog2(NumBytes), PtrW = SramAw+SDW+1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- base_index_i  in  SramAw  first SRAM word of the RX region
- limit_index_i  in  SramAw  last SRAM word of the RX region (inclusive)
- timer_v  in  8  idle cycles before a partial word is flushed
- abort  in  1  drop buffered, unwritten bytes
- rptr  in  PtrW  software read pointer (phase bit, word index, byte offset)
- wptr  out  PtrW  write pointer
- depth  out  PtrW  bytes held in the SRAM region
- full  out  1  region full at word granularity
- fifo_valid  in  1  RX FIFO byte available
- fifo_ready  out  1  pop strobe
- fifo_rdata  in  FifoDw  RX FIFO byte
- sram_req  out  1  SRAM request
- sram_write  out  1  write enable
- sram_addr  out  SramAw  word address
- sram_wdata  out  SramDw  write data
- sram_wmask  out  SramDw  bit write mask (byte lanes)
- sram_gnt  in  1  grant
- sram_rvalid  in  1  unused
- sram_rdata  in  SramDw  unused
- sram_error  in  2  unused

Behaviour:
- Reset: st=StIdle; wptr, pos, word buffer, byte mask and idle counter all 0. Every output is 0 during reset; in particular full=0 and depth=0.
- Region size: limit = limit_index_i - base_index_i (words - 1).
- full = (wptr[PtrW-1] != rptr[PtrW-1]) && (wptr[PtrW-2:SDW] == rptr[PtrW-2:SDW]).
- depth, same phase: {0,wptr[PtrW-2:0]} - {0,rptr[PtrW-2:0]}.
- depth, phase differs: {0,wptr[PtrW-2:0]} + ({0,limit,SDW'1s} - {0,rptr[PtrW-2:0]}) + 1.
- sram_addr = base_index_i + wptr[PtrW-2:SDW], combinational.
- StIdle:
  - Load pos <= wptr[SDW-1:0]; clear the mask.
  - If fifo_valid && !full, go to StPop.
- StPop:
  - fifo_ready=1.
  - On fifo_valid: write byte into lane pos, set that lane's mask byte to FFh, pos+1, clear the idle counter.
  - If the accepted byte is in lane NumBytes-1, go to StWrite.
  - If !fifo_valid, the idle counter increments. When the counter == timer_v, go to StWrite. With timer_v=0, flush on the first idle cycle.
  - abort (highest priority in StPop): go to StIdle with no write; wptr unchanged; the current cycle's byte is not popped (fifo_ready=0 that cycle).
- StWrite:
  - sram_req=1, sram_write=1; sram_wdata and sram_wmask are registered.
  - Hold all outputs stable until sram_gnt; on sram_gnt go to StUpdate.
  - abort is ignored in StWrite.
- StUpdate: one cycle, then StIdle.
  - If pos wrapped to 0 (word complete) and word index != limit: word index +1, byte offset 0.
  - If pos wrapped to 0 and word index == limit: word index 0, phase bit toggles, byte offset 0.
  - Otherwise: byte offset <= pos, word index unchanged.
- Masked partial words: the next entry resumes at the stored offset and masks only the new lanes, so earlier bytes in SRAM are preserved.
- sram_req and sram_write are 0 outside StWrite. fifo_ready is 0 outside StPop.
- Changing base_index_i or limit_index_i while not idle is undefined.

Test Plan:
- base=0x100, limit=0x10F, pushes 11,22,33,44 -> one write at addr 0x100, wdata 0x44332211, wmask 0xFFFFFFFF; wptr=0x004; depth=4.
- timer_v=3, push AA,BB then idle -> write on the 4th idle cycle, wmask 0x0000FFFF, wptr=0x002. Then push CC,DD -> write at the same addr, wmask 0xFFFF0000, wptr=0x004.
- wptr word=15 (limit 0x10F), offset 0, four bytes -> write at 0x10F; wptr phase=1, word 0, offset 0. With rptr=0: full=1, depth=64, fifo_ready stays 0.
- sram_gnt held low 5 cycles -> sram_req, sram_addr, sram_wdata and sram_wmask stable; no pops; wptr updates one cycle after gnt.
- Two bytes pushed, then abort -> no sram_req, wptr unchanged, return to StIdle.
- Reset asserted mid-StWrite -> sram_req drops asynchronously; wptr=0, depth=0.

Source files
------------

// File: rtl/spi_fwm_rxf_ctrl.sv
// spi_fwm_rxf_ctrl: packs RX FIFO bytes little-endian into SRAM words and
// writes them into a circular base/limit region with per-byte masks.
//
// Ports:
//   clk_i, rst_i                  clock, async active-high reset
//   base_index_i, limit_index_i   first / last (inclusive) word of the region
//   timer_v                       idle cycles before a partial word is flushed
//   abort                         drop buffered, unwritten bytes (pop state only)
//   rptr                          software read pointer {phase, word, byte}
//   wptr, depth, full             write pointer, bytes held, word-level full
//   fifo_valid/ready/rdata        RX byte FIFO pop interface
//   sram_*                        SRAM write port (read-side inputs unused)
module spi_fwm_rxf_ctrl #(
    parameter  int FifoDw   = 8,
    parameter  int SramAw   = 11,
    parameter  int SramDw   = 32,
    localparam int NumBytes = SramDw / 8,
    localparam int SDW      = $clog2(NumBytes),
    localparam int PtrW     = SramAw + SDW + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [SramAw-1:0] base_index_i,
    input  logic [SramAw-1:0] limit_index_i,
    input  logic [7:0]        timer_v,
    input  logic              abort,
    input  logic [PtrW-1:0]   rptr,
    output logic [PtrW-1:0]   wptr,
    output logic [PtrW-1:0]   depth,
    output logic              full,
    input  logic              fifo_valid,
    output logic              fifo_ready,
    input  logic [FifoDw-1:0] fifo_rdata,
    output logic              sram_req,
    output logic              sram_write,
    output logic [SramAw-1:0] sram_addr,
    output logic [SramDw-1:0] sram_wdata,
    output logic [SramDw-1:0] sram_wmask,
    input  logic              sram_gnt,
    input  logic              sram_rvalid,
    input  logic [SramDw-1:0] sram_rdata,
    input  logic [1:0]        sram_error
);

    typedef enum logic [1:0] {
        StIdle,
        StPop,
        StWrite,
        StUpdate
    } st_e;

    st_e               r_st;
    logic [PtrW-1:0]   r_wptr;
    logic [SDW-1:0]    r_pos;
    logic [SramDw-1:0] r_wdata;
    logic [SramDw-1:0] r_wmask;
    logic [7:0]        r_idle;

    logic [SramAw-1:0] w_limit;
    logic [SramAw-1:0] w_wword;
    logic [SramAw-1:0] w_rword;
    logic              w_phase_eq;
    logic              w_full;
    logic [PtrW-1:0]   w_wlin;
    logic [PtrW-1:0]   w_rlin;
    logic [PtrW-1:0]   w_top;
    logic [PtrW-1:0]   w_depth;
    logic              w_last;
    logic              w_unused;

    assign w_limit    = limit_index_i - base_index_i;
    assign w_wword    = r_wptr[PtrW-2:SDW];
    assign w_rword    = rptr[PtrW-2:SDW];
    assign w_phase_eq = (r_wptr[PtrW-1] == rptr[PtrW-1]);
    assign w_full     = !w_phase_eq && (w_wword == w_rword);
    assign w_last     = (r_pos == SDW'(NumBytes - 1));

    // Linear byte positions inside one lap; w_top is the last byte of the region.
    assign w_wlin = {1'b0, r_wptr[PtrW-2:0]};
    assign w_rlin = {1'b0, rptr[PtrW-2:0]};
    assign w_top  = {1'b0, w_limit, {SDW{1'b1}}};

    always_comb begin
        w_depth = '0;
        if (w_phase_eq) begin
            w_depth = w_wlin - w_rlin;
        end else begin
            w_depth = w_wlin + (w_top - w_rlin) + PtrW'(1);
        end
    end

    assign w_unused = ^{sram_rvalid, sram_rdata, sram_error};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_st    <= StIdle;
            r_wptr  <= '0;
            r_pos   <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_idle  <= '0;
        end else begin
            unique case (r_st)
                StIdle: begin
                    // Resume at the stored byte offset so a partial word keeps
                    // its earlier lanes untouched in SRAM.
                    r_pos   <= r_wptr[SDW-1:0];
                    r_wdata <= '0;
                    r_wmask <= '0;
                    r_idle  <= '0;
                    if (fifo_valid && !w_full) begin
                        r_st <= StPop;
                    end
                end
                StPop: begin
                    if (abort) begin
                        r_st <= StIdle;
                    end else if (fifo_valid) begin
                        for (int i = 0; i < NumBytes; i++) begin
                            if (r_pos == SDW'(i)) begin
                                r_wdata[i*8 +: 8] <= fifo_rdata;
                                r_wmask[i*8 +: 8] <= 8'hFF;
                            end
                        end
                        r_pos  <= r_pos + SDW'(1);
                        r_idle <= '0;
                        if (w_last) begin
                            r_st <= StWrite;
                        end
                    end else if (r_idle == timer_v) begin
                        r_st <= StWrite;
                    end else begin
                        r_idle <= r_idle + 8'd1;
                    end
                end
                StWrite: begin
                    if (sram_gnt) begin
                        r_st <= StUpdate;
                    end
                end
                StUpdate: begin
                    r_st <= StIdle;
                    // Top lane written means the word is complete.
                    if (r_wmask[SramDw-1]) begin
                        r_wptr[SDW-1:0] <= '0;
                        if (w_wword == w_limit) begin
                            r_wptr[PtrW-2:SDW] <= '0;
                            r_wptr[PtrW-1]     <= ~r_wptr[PtrW-1];
                        end else begin
                            r_wptr[PtrW-2:SDW] <= w_wword + SramAw'(1);
                        end
                    end else begin
                        r_wptr[SDW-1:0] <= r_pos;
                    end
                end
                default: r_st <= StIdle;
            endcase
        end
    end

    assign wptr       = r_wptr;
    assign depth      = rst_i ? '0 : w_depth;
    assign full       = !rst_i && w_full;
    assign sram_addr  = rst_i ? '0 : (base_index_i + w_wword);
    assign fifo_ready = (r_st == StPop) && !abort;
    assign sram_req   = (r_st == StWrite);
    assign sram_write = (r_st == StWrite);
    assign sram_wdata = r_wdata;
    assign sram_wmask = r_wmask;

endmodule
